// File: rtl/uart_baud_timer.sv
// Baud/bit timing for the 16550 UART: hands the divisor to the shift-and-add multiplier, captures the
// bit period, then free-runs baudout and bit-boundary counters. Mid-bit strobe: UART_BAUD_TIMER_HALF_TICK_EN.
module uart_baud_timer #(
  parameter int unsigned DIVISOR_WIDTH    = 16,
  parameter int unsigned OVERSAMPLE_WIDTH = 8,
  parameter int unsigned OVERSAMPLE       = 16,
  localparam int unsigned PERIOD_WIDTH    = DIVISOR_WIDTH + OVERSAMPLE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIVISOR_WIDTH-1:0]    divisor,
  input  logic                        divisor_wr,
  input  logic                        sync,
  output logic [DIVISOR_WIDTH-1:0]    mult_multiplicand,
  output logic [OVERSAMPLE_WIDTH-1:0] mult_multiplier,
  output logic                        mult_start,
  input  logic                        mult_busy,
  input  logic [PERIOD_WIDTH-1:0]     mult_product,
  output logic [PERIOD_WIDTH-1:0]     period,
  output logic                        ready,
  output logic                        baudout,
  output logic                        bit_tick,
  output logic                        half_tick
);

  typedef enum logic [2:0] {StIdle, StReq, StWaitHi, StWaitLo, StRun} state_e;

  state_e                   state_q, state_d;
  logic [DIVISOR_WIDTH-1:0] div_q, div_d;
  logic                     pend_q, pend_d;
  logic [PERIOD_WIDTH-1:0]  period_q, period_d;
  logic [DIVISOR_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [PERIOD_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

  logic wr_nz, wr_z, baud_hit, bit_hit, tick_en;

  assign div_d    = divisor_wr ? divisor : div_q;
  assign wr_nz    = divisor_wr && (divisor != '0);
  assign wr_z     = divisor_wr && (divisor == '0);
  assign baud_hit = (div_cnt_q == div_q - DIVISOR_WIDTH'(1));
  assign bit_hit  = (bit_cnt_q == period_q - PERIOD_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      pend_q    <= 1'b0;
      period_q  <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      period_q  <= period_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    period_d = period_q;
    unique case (state_q)
      StIdle: begin
        if (wr_nz) state_d = StReq;
      end
      StReq: begin
        // The start pulse has already gone out with the old divisor, so rerun it afterwards.
        if (wr_nz) pend_d = 1'b1;
        state_d = wr_z ? StIdle : StWaitHi;
      end
      StWaitHi: begin
        if (divisor_wr) pend_d = 1'b1;
        if (mult_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (divisor_wr) pend_d = 1'b1;
        if (!mult_busy) begin
          period_d = mult_product;
          if (pend_q || divisor_wr) begin
            pend_d  = 1'b0;
            state_d = (div_d == '0) ? StIdle : StReq;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (divisor_wr) state_d = wr_z ? StIdle : StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters sit at phase 0 outside RUN so the first RUN cycle starts aligned.
  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = '0;
    if (state_q == StRun && !divisor_wr && !sync) begin
      div_cnt_d = baud_hit ? '0 : div_cnt_q + DIVISOR_WIDTH'(1);
      bit_cnt_d = bit_hit ? '0 : bit_cnt_q + PERIOD_WIDTH'(1);
    end
  end

  always_comb begin
    mult_start = (state_q == StReq);
    ready      = (state_q == StRun);
    tick_en    = (state_q == StRun) && !(sync && !divisor_wr);
    baudout    = tick_en && baud_hit;
    bit_tick   = tick_en && bit_hit;
`ifdef UART_BAUD_TIMER_HALF_TICK_EN
    if (period_q == PERIOD_WIDTH'(1)) begin
      half_tick = tick_en && bit_hit;
    end else begin
      half_tick = tick_en && (bit_cnt_q == (period_q >> 1) - PERIOD_WIDTH'(1));
    end
`else
    half_tick  = 1'b0;
`endif
  end

  assign mult_multiplicand = div_q;
  assign mult_multiplier   = OVERSAMPLE_WIDTH'(OVERSAMPLE);
  assign period            = period_q;

endmodule
